matmul_lanes: RTL and testbench

Parametrised successor to the single-MAC matrix-multiply top. Computes Z = X·Y for N×N signed matrices using LANES parallel MAC lanes, so LANES output columns are produced per pass. Y and Z are each split into LANES memory banks built from the existing `bram`. Host write/read ports keep flat row-major addressing; banking is invisible to the host. Adds a busy flag, saturating or truncating output, and write-conflict detection.

---
 rtl/matmul_pkg.sv | 43 ++++
 rtl/bram.sv | 23 ++
 rtl/mac_lane.sv | 47 ++++
 rtl/matmul_lanes.sv | 174 +++++++++++++++++
 tb/tb_matmul_lanes.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the banked multi-lane matrix multiplier.
// State encoding, accumulator sizing and output conversion live here.
package matmul_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      DRAIN,
      WRITE,
      DONE
   } state_t;

   localparam int CONV_W = 128;

   function automatic int acc_width(int dw, int log_n);
      return 2 * dw + log_n;
   endfunction

   // Caller keeps the low dw bits of the result.
   function automatic logic signed [CONV_W-1:0] sat_trunc(
      logic signed [CONV_W-1:0] v,
      int                       dw,
      bit                       sat
   );
      logic signed [CONV_W-1:0] one;
      logic signed [CONV_W-1:0] hi;
      logic signed [CONV_W-1:0] lo;
      logic signed [CONV_W-1:0] r;
      one    = '0;
      one[0] = 1'b1;
      hi     = (one <<< (dw - 1)) - one;
      lo     = -(one <<< (dw - 1));
      r      = v;
      if (sat) begin
         if (v > hi)
            r = hi;
         else if (v < lo)
            r = lo;
      end
      return r;
   endfunction

endpackage

// File: rtl/bram.sv
// Simple dual-port block RAM, one write port and one registered read port.
// Contents are never reset.
module bram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= din;
      dout <= mem[raddr];
   end

endmodule

// File: rtl/mac_lane.sv
// One multiply-accumulate lane: registered product, wide accumulator,
// and saturating or truncating conversion back to element width.
module mac_lane
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LOG_N      = 5,
   parameter int SATURATE   = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   input  logic                         vld,
   input  logic                         first,
   input  logic                         clr,
   output logic        [DATA_WIDTH-1:0] q
);

   localparam int PW    = 2 * DATA_WIDTH;
   localparam int ACC_W = acc_width(DATA_WIDTH, LOG_N);

   logic signed [PW-1:0]    prod;
   logic                    pv;
   logic                    pf;
   logic signed [ACC_W-1:0] acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod <= '0;
         pv   <= 1'b0;
         pf   <= 1'b0;
         acc  <= '0;
      end else begin
         prod <= PW'(a) * PW'(b);
         pv   <= vld;
         pf   <= first;
         if (clr)
            acc <= '0;
         else if (pv)
            acc <= pf ? ACC_W'(prod) : acc + ACC_W'(prod);
      end
   end

   assign q = DATA_WIDTH'(sat_trunc(CONV_W'(acc), DATA_WIDTH, SATURATE != 0));

endmodule

// File: rtl/matmul_lanes.sv
// Z = X*Y with LANES parallel MAC lanes; Y and Z banked by column.
// Host sees flat row-major addressing for all three matrices.
module matmul_lanes
   import matmul_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int LOG_N      = 5,
   parameter  int LOG_LANES  = 2,
   parameter  int SATURATE   = 1,
   localparam int ADDR_WIDTH = 2 * LOG_N
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  wr_conflict,
   input  logic [DATA_WIDTH-1:0] x_din,
   input  logic [DATA_WIDTH-1:0] y_din,
   input  logic [ADDR_WIDTH-1:0] x_wr_addr,
   input  logic [ADDR_WIDTH-1:0] y_wr_addr,
   input  logic                  x_wr_en,
   input  logic                  y_wr_en,
   input  logic [ADDR_WIDTH-1:0] z_rd_addr,
   output logic [DATA_WIDTH-1:0] z_dout
);

   localparam int N     = 2**LOG_N;
   localparam int LANES = 2**LOG_LANES;
   localparam int BAW   = ADDR_WIDTH - LOG_LANES;
   localparam logic [ADDR_WIDTH-1:0] LMASK = ADDR_WIDTH'(LANES - 1);

   state_t state, state_nx;

   logic [LOG_N-1:0]      i_q;
   logic [LOG_N-1:0]      k_q;
   logic [LOG_N-1:0]      colb;
   logic                  drn;
   logic                  v1;
   logic                  f1;
   logic [ADDR_WIDTH-1:0] zsel;

   logic idle, accept, last_k, last_g, last_i;
   logic [ADDR_WIDTH-1:0] y_rflat, z_wflat;
   logic [DATA_WIDTH-1:0] xq;
   logic [DATA_WIDTH-1:0] yq   [LANES];
   logic [DATA_WIDTH-1:0] zin  [LANES];
   logic [DATA_WIDTH-1:0] zq   [LANES];

   assign idle    = state == IDLE;
   assign accept  = idle && start;
   assign last_k  = k_q == LOG_N'(N - 1);
   assign last_i  = i_q == LOG_N'(N - 1);
   assign last_g  = colb == LOG_N'(N - LANES);
   assign y_rflat = {k_q, colb};
   assign z_wflat = {i_q, colb};

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state)
         IDLE:  if (start) state_nx = RUN;
         RUN: begin
            busy = 1'b1;
            if (last_k) state_nx = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (drn) state_nx = WRITE;
         end
         WRITE: begin
            busy     = 1'b1;
            state_nx = (last_i && last_g) ? DONE : RUN;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         i_q         <= '0;
         k_q         <= '0;
         colb        <= '0;
         drn         <= 1'b0;
         v1          <= 1'b0;
         f1          <= 1'b0;
         wr_conflict <= 1'b0;
         zsel        <= '0;
      end else begin
         state <= state_nx;
         v1    <= state == RUN;
         f1    <= (state == RUN) && (k_q == '0);
         zsel  <= z_rd_addr & LMASK;
         if (accept)
            wr_conflict <= 1'b0;
         else if (busy && (x_wr_en || y_wr_en))
            wr_conflict <= 1'b1;
         if (accept) begin
            i_q  <= '0;
            k_q  <= '0;
            colb <= '0;
            drn  <= 1'b0;
         end
         if (state == RUN)
            k_q <= k_q + 1'b1;
         if (state == DRAIN)
            drn <= ~drn;
         if (state == WRITE) begin
            colb <= colb + LOG_N'(LANES);
            if (last_g)
               i_q <= i_q + 1'b1;
         end
      end
   end

   bram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_x (
      .clk   (clk),
      .we    (idle && x_wr_en),
      .waddr (x_wr_addr),
      .din   (x_din),
      .raddr ({i_q, k_q}),
      .dout  (xq)
   );

   // Bank index is the low column bits; the rest is the in-bank address.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      bram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(BAW)) u_y (
         .clk   (clk),
         .we    (idle && y_wr_en && ((y_wr_addr & LMASK) == ADDR_WIDTH'(l))),
         .waddr (y_wr_addr[ADDR_WIDTH-1:LOG_LANES]),
         .din   (y_din),
         .raddr (y_rflat[ADDR_WIDTH-1:LOG_LANES]),
         .dout  (yq[l])
      );

      mac_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .LOG_N      (LOG_N),
         .SATURATE   (SATURATE)
      ) u_mac (
         .clk   (clk),
         .rst_n (rst_n),
         .a     (xq),
         .b     (yq[l]),
         .vld   (v1),
         .first (f1),
         .clr   (state == WRITE),
         .q     (zin[l])
      );

      bram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(BAW)) u_z (
         .clk   (clk),
         .we    (state == WRITE),
         .waddr (z_wflat[ADDR_WIDTH-1:LOG_LANES]),
         .din   (zin[l]),
         .raddr (z_rd_addr[ADDR_WIDTH-1:LOG_LANES]),
         .dout  (zq[l])
      );
   end

   always_comb begin
      z_dout = '0;
      for (int l = 0; l < LANES; l++)
         if (zsel == ADDR_WIDTH'(l))
            z_dout = zq[l];
   end

endmodule

// File: tb/tb_matmul_lanes.sv
// Bench for matmul_lanes: four configurations driven in parallel and
// checked against a plain-arithmetic matrix model and a cycle-count model.
module tb_matmul_lanes;

   localparam int DW = 16;
   localparam int LN = 2;
   localparam int AW = 4;
   localparam int ND = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic [DW-1:0] x_din = '0;
   logic [DW-1:0] y_din = '0;
   logic [AW-1:0] x_wr_addr = '0;
   logic [AW-1:0] y_wr_addr = '0;
   logic [AW-1:0] z_rd_addr = '0;
   logic x_wr_en = 1'b0;
   logic y_wr_en = 1'b0;

   logic busy_o [ND];
   logic done_o [ND];
   logic wrc_o  [ND];
   logic [DW-1:0] zd [ND];

   always #5 clk = ~clk;

   // d0: 2 lanes sat, d1: 2 lanes trunc, d2: 1 lane sat, d3: 4 lanes sat
   for (genvar g = 0; g < ND; g++) begin : g_dut
      matmul_lanes #(
         .DATA_WIDTH (DW),
         .LOG_N      (LN),
         .LOG_LANES  (g == 2 ? 0 : (g == 3 ? 2 : 1)),
         .SATURATE   (g == 1 ? 0 : 1)
      ) u (
         .clk         (clk),
         .rst_n       (rst_n),
         .start       (start),
         .busy        (busy_o[g]),
         .done        (done_o[g]),
         .wr_conflict (wrc_o[g]),
         .x_din       (x_din),
         .y_din       (y_din),
         .x_wr_addr   (x_wr_addr),
         .y_wr_addr   (y_wr_addr),
         .x_wr_en     (x_wr_en),
         .y_wr_en     (y_wr_en),
         .z_rd_addr   (z_rd_addr),
         .z_dout      (zd[g])
      );
   end

   int total = 0;
   int bad = 0;
   int xm [16];
   int ym [16];
   int lat_exp [ND] = '{57, 57, 113, 29};
   logic [DW-1:0] got [ND][16];
   bit cmp_en = 1'b0;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] expz(input int d, input int a);
      longint s;
      int i;
      int j;
      s = 0;
      i = a / 4;
      j = a % 4;
      for (int k = 0; k < 4; k++)
         s += longint'(xm[i*4+k]) * longint'(ym[k*4+j]);
      if (d != 1) begin
         if (s > 32767) s = 32767;
         if (s < -32768) s = -32768;
      end
      return s[DW-1:0];
   endfunction

   // Cycle-count model: busy for cycles 1..T-1 after acceptance, done at T.
   bit m_run [ND];
   int m_cyc [ND];
   bit m_wc  [ND];

   always @(posedge clk or negedge rst_n) begin
      for (int d = 0; d < ND; d++) begin
         if (!rst_n) begin
            m_run[d] <= 1'b0;
            m_cyc[d] <= 0;
            m_wc[d]  <= 1'b0;
         end else begin
            if (m_run[d] && m_cyc[d] < lat_exp[d] && (x_wr_en || y_wr_en))
               m_wc[d] <= 1'b1;
            if (m_run[d]) begin
               m_cyc[d] <= m_cyc[d] + 1;
               if (m_cyc[d] >= lat_exp[d])
                  m_run[d] <= 1'b0;
            end else if (start) begin
               m_run[d] <= 1'b1;
               m_cyc[d] <= 1;
               m_wc[d]  <= 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && cmp_en) begin
         for (int d = 0; d < ND; d++) begin
            chk($sformatf("busy%0d", d), longint'(busy_o[d]),
                longint'(m_run[d] && m_cyc[d] < lat_exp[d]));
            chk($sformatf("done%0d", d), longint'(done_o[d]),
                longint'(m_run[d] && m_cyc[d] == lat_exp[d]));
            chk($sformatf("wrc%0d", d), longint'(wrc_o[d]),
                longint'(m_wc[d]));
         end
      end
   end

   task automatic load();
      for (int a = 0; a < 16; a++) begin
         @(negedge clk);
         x_wr_en   = 1'b1;
         y_wr_en   = 1'b1;
         x_wr_addr = AW'(a);
         y_wr_addr = AW'(a);
         x_din     = DW'(xm[a]);
         y_din     = DW'(ym[a]);
      end
      @(negedge clk);
      x_wr_en = 1'b0;
      y_wr_en = 1'b0;
   endtask

   // mode 0 plain, 1 start/write pokes mid-run, 2 reset at cycle 20
   task automatic run(input int mode);
      int n;
      int lat [ND];
      bit all;
      for (int d = 0; d < ND; d++) lat[d] = -1;
      @(negedge clk);
      start = 1'b1;
      n = 0;
      while (n < 300) begin
         @(negedge clk);
         n++;
         start     = (mode == 1 && n == 10);
         x_wr_en   = (mode == 1 && n == 12);
         x_wr_addr = '0;
         x_din     = 16'd99;
         if (n == 2)
            chk("wrc_clr", longint'(wrc_o[0]), 0);
         if (mode == 2 && n == 20) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_busy", longint'(busy_o[0]), 0);
            chk("rst_done", longint'(done_o[0]), 0);
            chk("rst_wrc", longint'(wrc_o[0]), 0);
            @(negedge clk);
            #2 rst_n = 1'b1;
            return;
         end
         all = 1'b1;
         for (int d = 0; d < ND; d++) begin
            if (done_o[d] && lat[d] < 0) lat[d] = n;
            if (lat[d] < 0) all = 1'b0;
         end
         if (all) break;
      end
      x_wr_en = 1'b0;
      start   = 1'b0;
      for (int d = 0; d < ND; d++)
         chk($sformatf("lat%0d", d), lat[d], lat_exp[d]);
      @(negedge clk);
   endtask

   task automatic readback();
      for (int a = 0; a < 16; a++) begin
         @(negedge clk);
         z_rd_addr = AW'(a);
         @(negedge clk);
         for (int d = 0; d < ND; d++) begin
            got[d][a] = zd[d];
            chk($sformatf("z%0d_%0d", d, a), longint'(zd[d]),
                longint'(expz(d, a)));
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         chk("reset_busy", longint'(busy_o[d]), 0);
         chk("reset_done", longint'(done_o[d]), 0);
         chk("reset_wrc", longint'(wrc_o[d]), 0);
      end
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      for (int a = 0; a < 16; a++) begin
         xm[a] = (a / 4 == a % 4) ? 1 : 0;
         ym[a] = a + 1;
      end
      load();
      run(0);
      readback();
      chk("ident_z5", longint'(got[0][5]), 6);
      chk("ident_l1_z0", longint'(got[2][0]), 1);
      chk("ident_l4_z15", longint'(got[3][15]), 16);

      for (int a = 0; a < 16; a++) begin
         xm[a] = -1;
         ym[a] = 3;
      end
      load();
      run(0);
      readback();
      chk("neg_z0", longint'(got[0][0]), 16'hFFF4);

      for (int a = 0; a < 16; a++) begin
         xm[a] = 32767;
         ym[a] = 32767;
      end
      load();
      run(0);
      readback();
      chk("satpos_z3", longint'(got[0][3]), 16'h7FFF);
      chk("trunc_z3", longint'(got[1][3]), 16'h0004);

      for (int a = 0; a < 16; a++) begin
         xm[a] = -32768;
         ym[a] = 32767;
      end
      load();
      run(0);
      readback();
      chk("satneg_z0", longint'(got[0][0]), 16'h8000);

      for (int a = 0; a < 16; a++) begin
         xm[a] = (a / 4 == a % 4) ? 1 : 0;
         ym[a] = a + 1;
      end
      load();
      run(1);
      chk("conflict_set", longint'(wrc_o[0]), 1);
      readback();
      chk("conflict_z0", longint'(got[0][0]), 1);

      run(2);
      run(0);
      readback();
      chk("rst_restart_z10", longint'(got[0][10]), 11);

      for (int it = 0; it < 2; it++) begin
         for (int a = 0; a < 16; a++) begin
            xm[a] = int'($signed(16'($urandom)));
            ym[a] = int'($signed(16'($urandom)));
         end
         load();
         run(0);
         readback();
      end

      cmp_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
